// File: rtl/pivot_pkg.sv
// Shared types and helpers for the greedy pivot scheduler.
// Holds the FSM state encoding and the index-width function.
package pivot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    EMIT,
    FINISH
  } sched_state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pivot_sched_tag_delay.sv
// Fixed-depth valid/data shift register that travels alongside memory reads
// so each response can be attributed to the cell that requested it.
module tag_delay #(
  parameter int LAT = 1,
  parameter int DW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          pending
);

  logic [LAT-1:0] v;
  logic [DW-1:0]  d [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < LAT; k++) d[k] <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      v[0] <= in_valid;
      d[0] <= in_data;
      for (int k = 1; k < LAT; k++) begin
        v[k] <= v[k-1];
        d[k] <= d[k-1];
      end
    end
  end

  assign out_valid = v[LAT-1];
  assign out_data  = d[LAT-1];

  // Stages not yet at the output; the output stage is consumed this cycle.
  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < LAT - 1; k++) pending = pending | v[k];
  end

endmodule

// File: rtl/pivot_sched.sv
// Greedy pivot scheduler: each round picks the largest entry among unused
// rows and columns, hands it to a consumer, then retires that row and column.
module pivot_sched
  import pivot_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int N_STOCKS = 4,
  parameter int RD_LAT   = 1,
  localparam int IW      = idx_w(N_STOCKS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            mem_rd_en,
  output logic [2*IW-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic            piv_valid,
  input  logic            piv_ready,
  output logic [IW-1:0]   piv_i,
  output logic [IW-1:0]   piv_j,
  output logic [WIDTH-1:0] piv_val,
  output logic [IW-1:0]   piv_round
);

  localparam int TW = 2 * IW;

  sched_state_t        state;
  logic [N_STOCKS-1:0] row_used;
  logic [N_STOCKS-1:0] col_used;
  logic [IW-1:0]       round;
  logic [IW:0]         cur_i;
  logic [IW-1:0]       cur_j;

  logic                best_valid;
  logic [IW-1:0]       best_i;
  logic [IW-1:0]       best_j;
  logic [WIDTH-1:0]    best_val;

  logic                nb_valid;
  logic [IW-1:0]       nb_i;
  logic [IW-1:0]       nb_j;
  logic [WIDTH-1:0]    nb_val;

  logic                found;
  logic [IW-1:0]       f_i;
  logic [IW-1:0]       f_j;

  logic                tag_valid;
  logic [TW-1:0]       tag_data;
  logic                pending;
  logic                kill;
  logic                last_round;

  assign kill       = abort && (state != IDLE);
  assign last_round = (int'(round) == N_STOCKS - 1);

  tag_delay #(
    .LAT (RD_LAT),
    .DW  (TW)
  ) u_tag (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (kill),
    .in_valid  (mem_rd_en),
    .in_data   (mem_rd_addr),
    .out_valid (tag_valid),
    .out_data  (tag_data),
    .pending   (pending)
  );

  // Next eligible cell at or after the cursor, row-major.
  always_comb begin
    found = 1'b0;
    f_i   = '0;
    f_j   = '0;
    for (int i = 0; i < N_STOCKS; i++) begin
      for (int j = 0; j < N_STOCKS; j++) begin
        if (!found && !row_used[i] && !col_used[j] &&
            (i > int'(cur_i) ||
             (i == int'(cur_i) && j >= int'(cur_j)))) begin
          found = 1'b1;
          f_i   = IW'(i);
          f_j   = IW'(j);
        end
      end
    end
  end

  // First response wins unconditionally; later ones only if strictly larger.
  always_comb begin
    nb_valid = best_valid;
    nb_i     = best_i;
    nb_j     = best_j;
    nb_val   = best_val;
    if (tag_valid && (!best_valid || mem_rd_data > best_val)) begin
      nb_valid = 1'b1;
      nb_i     = tag_data[TW-1:IW];
      nb_j     = tag_data[IW-1:0];
      nb_val   = mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      piv_valid   <= 1'b0;
      piv_i       <= '0;
      piv_j       <= '0;
      piv_val     <= '0;
      piv_round   <= '0;
      row_used    <= '0;
      col_used    <= '0;
      round       <= '0;
      cur_i       <= '0;
      cur_j       <= '0;
      best_valid  <= 1'b0;
      best_i      <= '0;
      best_j      <= '0;
      best_val    <= '0;
    end else begin
      best_valid <= nb_valid;
      best_i     <= nb_i;
      best_j     <= nb_j;
      best_val   <= nb_val;
      done       <= 1'b0;
      mem_rd_en  <= 1'b0;
      if (kill) begin
        state      <= IDLE;
        busy       <= 1'b0;
        piv_valid  <= 1'b0;
        best_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              row_used   <= '0;
              col_used   <= '0;
              round      <= '0;
              cur_i      <= '0;
              cur_j      <= '0;
              best_valid <= 1'b0;
              busy       <= 1'b1;
              state      <= SCAN;
            end
          end
          SCAN: begin
            if (found) begin
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= {f_i, f_j};
              if (int'(f_j) == N_STOCKS - 1) begin
                cur_i <= {1'b0, f_i} + 1'b1;
                cur_j <= '0;
              end else begin
                cur_i <= {1'b0, f_i};
                cur_j <= f_j + 1'b1;
              end
            end else begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (!pending) begin
              state     <= EMIT;
              piv_valid <= 1'b1;
              piv_i     <= nb_i;
              piv_j     <= nb_j;
              piv_val   <= nb_val;
              piv_round <= round;
            end
          end
          EMIT: begin
            if (piv_ready) begin
              piv_valid       <= 1'b0;
              row_used[piv_i] <= 1'b1;
              col_used[piv_j] <= 1'b1;
              round           <= round + 1'b1;
              if (last_round) begin
                state <= FINISH;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state      <= SCAN;
                cur_i      <= '0;
                cur_j      <= '0;
                best_valid <= 1'b0;
              end
            end
          end
          FINISH: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pivot_sched.sv
// Bench for pivot_sched: two instances (read latency 1 and 3) share stimulus
// and are checked against a greedy max-pivot reference model.
module tb_pivot_sched;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int BUDGET = 3000;

  typedef struct packed {
    logic [IW-1:0] r;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [W-1:0]  v;
  } piv_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic piv_ready = 1'b1;

  logic            busy [2];
  logic            done [2];
  logic            rd_en [2];
  logic [2*IW-1:0] rd_addr [2];
  logic [W-1:0]    rd_data [2];
  logic            pv [2];
  logic [IW-1:0]   pi [2];
  logic [IW-1:0]   pj [2];
  logic [W-1:0]    pval [2];
  logic [IW-1:0]   pr [2];

  logic [W-1:0] A [N][N];
  piv_t exp_p [N];

  int vectors = 0;
  int miscompares = 0;

  piv_t got [2][256];
  int piv_cnt [2];
  int rd_cnt [2];
  int done_cnt [2];
  int b_piv [2];
  int b_rd [2];
  int b_done [2];

  always #5 clk = ~clk;

  pivot_sched #(.WIDTH(W), .N_STOCKS(N), .RD_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy[0]), .done(done[0]),
    .mem_rd_en(rd_en[0]), .mem_rd_addr(rd_addr[0]),
    .mem_rd_data(rd_data[0]),
    .piv_valid(pv[0]), .piv_ready(piv_ready),
    .piv_i(pi[0]), .piv_j(pj[0]), .piv_val(pval[0]),
    .piv_round(pr[0])
  );

  pivot_sched #(.WIDTH(W), .N_STOCKS(N), .RD_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy[1]), .done(done[1]),
    .mem_rd_en(rd_en[1]), .mem_rd_addr(rd_addr[1]),
    .mem_rd_data(rd_data[1]),
    .piv_valid(pv[1]), .piv_ready(piv_ready),
    .piv_i(pi[1]), .piv_j(pj[1]), .piv_val(pval[1]),
    .piv_round(pr[1])
  );

  // Matrix memories: data appears exactly L cycles after the strobe,
  // with random garbage on cycles that carry no response.
  for (genvar k = 0; k < 2; k++) begin : g_mem
    localparam int L = (k == 0) ? 1 : 3;
    logic [W-1:0] dq [L];
    always @(posedge clk) begin
      dq[0] <= rd_en[k] ? A[rd_addr[k][2*IW-1:IW]][rd_addr[k][IW-1:0]]
                        : W'($urandom);
      for (int s = 1; s < L; s++) dq[s] <= dq[s-1];
    end
    assign rd_data[k] = dq[L-1];
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      piv_cnt[k] = 0;
      rd_cnt[k] = 0;
      done_cnt[k] = 0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (rd_en[k]) rd_cnt[k] <= rd_cnt[k] + 1;
        if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
        if (pv[k] && piv_ready) begin
          got[k][piv_cnt[k] % 256] <= {pr[k], pi[k], pj[k], pval[k]};
          piv_cnt[k] <= piv_cnt[k] + 1;
        end
      end
    end
  end

  // Greedy reference: largest remaining entry, earliest row-major on ties.
  task automatic model();
    bit ru [N];
    bit cu [N];
    for (int i = 0; i < N; i++) begin
      ru[i] = 1'b0;
      cu[i] = 1'b0;
    end
    for (int r = 0; r < N; r++) begin
      bit found = 1'b0;
      int bi = 0;
      int bj = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (!ru[i] && !cu[j] && (!found || A[i][j] > A[bi][bj])) begin
            found = 1'b1;
            bi = i;
            bj = j;
          end
      ru[bi] = 1'b1;
      cu[bj] = 1'b1;
      exp_p[r] = {IW'(r), IW'(bi), IW'(bj), A[bi][bj]};
    end
  endtask

  task automatic load_a();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        A[i][j] = W'(4 * i + j + 1);
  endtask

  task automatic mark();
    for (int k = 0; k < 2; k++) begin
      b_piv[k] = piv_cnt[k];
      b_rd[k] = rd_cnt[k];
      b_done[k] = done_cnt[k];
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_seq(input bit rnd_ready, input string name);
    int t = 0;
    mark();
    pulse_start();
    while (!(done_cnt[0] > b_done[0] && done_cnt[1] > b_done[1]) &&
           t < BUDGET) begin
      piv_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      t++;
    end
    piv_ready = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (t >= BUDGET) begin
      miscompares++;
      $display("FAIL %s timeout: no done after %0d cycles", name, t);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({busy[k], done[k], rd_en[k], rd_addr[k], pv[k], pi[k], pj[k],
           pval[k], pr[k]} !== '0) begin
        miscompares++;
        $display("FAIL reset[%0d]: outputs %b, want all 0", k,
                 {busy[k], done[k], rd_en[k], rd_addr[k], pv[k]});
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_matrix_a();
    load_a();
    model();
    run_seq(1'b0, "matrix_a");
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (piv_cnt[k] - b_piv[k] != N || rd_cnt[k] - b_rd[k] != 30 ||
          done_cnt[k] - b_done[k] != 1) begin
        miscompares++;
        $display("FAIL matrix_a_counts[%0d]: piv %0d rd %0d done %0d, want 4 30 1",
                 k, piv_cnt[k] - b_piv[k], rd_cnt[k] - b_rd[k],
                 done_cnt[k] - b_done[k]);
      end
      for (int r = 0; r < N; r++) begin
        vectors++;
        if (got[k][(b_piv[k] + r) % 256] !== exp_p[r]) begin
          miscompares++;
          $display("FAIL matrix_a_piv[%0d][%0d]: got %h, want %h", k, r,
                   got[k][(b_piv[k] + r) % 256], exp_p[r]);
        end
      end
    end
  endtask

  task automatic test_ties();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        A[i][j] = 16'd7;
    run_seq(1'b0, "ties");
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N; r++) begin
        piv_t want = {IW'(r), IW'(r), IW'(r), 16'd7};
        vectors++;
        if (got[k][(b_piv[k] + r) % 256] !== want) begin
          miscompares++;
          $display("FAIL ties_piv[%0d][%0d]: got %h, want %h", k, r,
                   got[k][(b_piv[k] + r) % 256], want);
        end
      end
  endtask

  task automatic test_stall();
    piv_t snap [2];
    int t = 0;
    load_a();
    model();
    mark();
    piv_ready = 1'b0;
    pulse_start();
    while (!(pv[0] && pv[1]) && t < 500) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 500) begin
      miscompares++;
      $display("FAIL stall_wait: piv_valid %b%b after %0d cycles, want 11",
               pv[1], pv[0], t);
    end
    for (int k = 0; k < 2; k++) begin
      snap[k] = {pr[k], pi[k], pj[k], pval[k]};
      vectors++;
      if (snap[k] !== exp_p[0]) begin
        miscompares++;
        $display("FAIL stall_round0[%0d]: got %h, want %h", k, snap[k],
                 exp_p[0]);
      end
    end
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({pv[k], rd_en[k], pr[k], pi[k], pj[k], pval[k]} !==
            {2'b10, snap[k]}) begin
          miscompares++;
          $display("FAIL stall_hold[%0d]: valid %b rd %b piv %h, want 1 0 %h",
                   k, pv[k], rd_en[k], {pr[k], pi[k], pj[k], pval[k]},
                   snap[k]);
        end
      end
    end
    piv_ready = 1'b1;
    t = 0;
    while (!(done_cnt[0] > b_done[0] && done_cnt[1] > b_done[1]) &&
           t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= BUDGET) begin
      miscompares++;
      $display("FAIL stall_done: no done after %0d cycles", t);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        A[i][j] = 16'd1;
    A[0][1] = 16'hFFFF;
    model();
    run_seq(1'b0, "latency");
    for (int k = 0; k < 2; k++) begin
      piv_t g1 = got[k][(b_piv[k] + 1) % 256];
      vectors++;
      if (got[k][b_piv[k] % 256] !== {2'd0, 2'd0, 2'd1, 16'hFFFF}) begin
        miscompares++;
        $display("FAIL latency_r0[%0d]: got %h, want 0001ffff", k,
                 got[k][b_piv[k] % 256]);
      end
      vectors++;
      if (g1.i == 0 || g1.j == 1 || g1 !== exp_p[1]) begin
        miscompares++;
        $display("FAIL latency_r1[%0d]: got %h, want %h", k, g1, exp_p[1]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          A[i][j] = (it % 2 == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
      model();
      run_seq(1'b1, "random");
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (rd_cnt[k] - b_rd[k] != 30 || done_cnt[k] - b_done[k] != 1) begin
          miscompares++;
          $display("FAIL random_counts[%0d] it%0d: rd %0d done %0d, want 30 1",
                   k, it, rd_cnt[k] - b_rd[k], done_cnt[k] - b_done[k]);
        end
        for (int r = 0; r < N; r++) begin
          vectors++;
          if (got[k][(b_piv[k] + r) % 256] !== exp_p[r]) begin
            miscompares++;
            $display("FAIL random_piv[%0d][%0d] it%0d: got %h, want %h", k, r,
                     it, got[k][(b_piv[k] + r) % 256], exp_p[r]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    load_a();
    mark();
    pulse_start();
    while (!(piv_cnt[0] - b_piv[0] >= 1 && rd_en[0]) && t < 500) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 500) begin
      miscompares++;
      $display("FAIL reset_mid_wait: round 1 scan not seen in %0d cycles", t);
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({busy[k], done[k], rd_en[k], rd_addr[k], pv[k], pi[k], pj[k],
           pval[k], pr[k]} !== '0) begin
        miscompares++;
        $display("FAIL reset_mid_zero[%0d]: busy %b rd %b addr %h valid %b, want 0",
                 k, busy[k], rd_en[k], rd_addr[k], pv[k]);
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (done_cnt[k] != b_done[k] || busy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_idle[%0d]: done %0d busy %b, want 0 0", k,
                 done_cnt[k] - b_done[k], busy[k]);
      end
    end
    test_matrix_a();
  endtask

  task automatic test_abort();
    int t = 0;
    load_a();
    model();
    mark();
    piv_ready = 1'b1;
    pulse_start();
    while (piv_cnt[0] - b_piv[0] < 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    piv_ready = 1'b0;
    while (!pv[0] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 1000 || pr[0] !== 2'd2) begin
      miscompares++;
      $display("FAIL abort_emit: round %0d after %0d cycles, want round 2",
               pr[0], t);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({pv[k], busy[k]} !== 2'b00) begin
        miscompares++;
        $display("FAIL abort_drop[%0d]: valid %b busy %b, want 0 0", k, pv[k],
                 busy[k]);
      end
    end
    piv_ready = 1'b1;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (done_cnt[k] != b_done[k]) begin
        miscompares++;
        $display("FAIL abort_nodone[%0d]: %0d done pulses, want 0", k,
                 done_cnt[k] - b_done[k]);
      end
    end
    // A second start while busy must not restart or disturb the sequence.
    mark();
    pulse_start();
    repeat (8) @(negedge clk);
    pulse_start();
    t = 0;
    while (!(done_cnt[0] > b_done[0] && done_cnt[1] > b_done[1]) &&
           t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (piv_cnt[k] - b_piv[k] != N || rd_cnt[k] - b_rd[k] != 30 ||
          done_cnt[k] - b_done[k] != 1 ||
          got[k][(b_piv[k] + N - 1) % 256] !== exp_p[N-1]) begin
        miscompares++;
        $display("FAIL restart_ignored[%0d]: piv %0d rd %0d done %0d, want 4 30 1",
                 k, piv_cnt[k] - b_piv[k], rd_cnt[k] - b_rd[k],
                 done_cnt[k] - b_done[k]);
      end
    end
  endtask

  initial begin
    load_a();
    test_reset();
    test_matrix_a();
    test_ties();
    test_stall();
    test_latency();
    test_random();
    test_reset_mid();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
